// File: rtl/upsampler_pkg.sv
// Shared types and constants for the 2x nearest-neighbour upsampler.
package upsampler_pkg;

  localparam int COORD_W = 16;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    EMIT_EVEN = 2'd1,
    EMIT_ODD  = 2'd2
  } state_e;

  // Output coordinate carried alongside the buffer read.
  typedef struct packed {
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
  } coord_t;

  // Assemble an fp word from its fields for a given exponent/fraction split.
  function automatic logic [63:0] fp_pack(input logic sign, input logic [31:0] expo,
                                          input logic [31:0] frac,
                                          input int unsigned exp_w, input int unsigned frac_w);
    return (64'(sign) << (exp_w + frac_w)) | (64'(expo) << frac_w) | 64'(frac);
  endfunction

  // +0.0: sign, exponent and fraction all clear.
  function automatic logic [63:0] fp_zero(input int unsigned exp_w, input int unsigned frac_w);
    return fp_pack(1'b0, 32'd0, 32'd0, exp_w, frac_w);
  endfunction

endpackage

// File: rtl/line_buffer_1r1w.sv
// Simple dual-port line buffer: one write port, one registered read port.
module line_buffer_1r1w #(
  parameter int DEPTH = 320,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
  end

  // Registered read port; holds last word when idle.
  always_ff @(posedge clk_i) begin
    if (re_i) r_rdata <= r_mem[raddr_i];
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/upsampler_0_fp16.sv
// 2x nearest-neighbour fp upsampler: buffers one input row, then emits it
// twice at double width. Optional UPSAMPLER_0_ZERO_STUFF_EN forces every
// position with odd col or odd row to +0.0 instead of replicating.
module upsampler_0_fp16
  import upsampler_pkg::*;
#(
  parameter int EXP_WIDTH  = 5,
  parameter int FRAC_WIDTH = 10,
  parameter int IN_WIDTH   = 320,
  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
  localparam int ADDR_WIDTH   = $clog2(IN_WIDTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [FP_WIDTH_REG-1:0] data_i,
  input  logic [COORD_W-1:0]      col_i,
  input  logic [COORD_W-1:0]      row_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [FP_WIDTH_REG-1:0] data_o,
  output logic [COORD_W-1:0]      col_o,
  output logic [COORD_W-1:0]      row_o,
  output logic                    valid_o
);

  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int STAGES = 2;
  localparam logic [ADDR_WIDTH-1:0] WR_LAST = ADDR_WIDTH'(IN_WIDTH - 1);
  localparam logic [CNT_W-1:0]      RD_LAST = CNT_W'(2 * IN_WIDTH - 1);

  state_e                  r_state, w_next;
  logic                    r_ready;
  logic [ADDR_WIDTH-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]        r_cnt;
  logic [COORD_W-1:0]      r_row_q;
  logic [STAGES:1]         r_vld_pipe;
  coord_t                  r_s1;
  logic [FP_WIDTH_REG-1:0] r_data_o;
  logic [COORD_W-1:0]      r_col_o, r_row_o;

  logic                    w_xfer, w_emit, w_last_wr, w_last_rd;
  logic [FP_WIDTH_REG-1:0] w_rd_data, w_out_data;
  logic                    w_unused_col;

  // col_i is informational; the write pointer addresses the buffer.
  assign w_unused_col = ^col_i;

  assign w_xfer    = valid_i & r_ready;
  assign w_emit    = (r_state != FILL);
  assign w_last_wr = w_xfer && (r_wr_ptr == WR_LAST);
  assign w_last_rd = w_emit && (r_cnt == RD_LAST);

  // Next-state: fill one row, then sweep it twice.
  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL:      if (w_last_wr) w_next = EMIT_EVEN;
      EMIT_EVEN: if (w_last_rd) w_next = EMIT_ODD;
      EMIT_ODD:  if (w_last_rd) w_next = FILL;
      default:   w_next = FILL;
    endcase
  end

  // State register; ready is registered so it stays low through reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= FILL;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == FILL);
    end
  end

  // Write pointer, latched row, and read sweep counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_row_q  <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_xfer) begin
        r_wr_ptr <= w_last_wr ? '0 : r_wr_ptr + 1'b1;
        r_row_q  <= row_i;
      end
      if (w_emit) r_cnt <= w_last_rd ? '0 : r_cnt + 1'b1;
    end
  end

  line_buffer_1r1w #(
    .DEPTH (IN_WIDTH),
    .WIDTH (FP_WIDTH_REG),
    .AW    (ADDR_WIDTH)
  ) u_lbuf (
    .clk_i   (clk_i),
    .we_i    (w_xfer),
    .waddr_i (r_wr_ptr),
    .wdata_i (data_i),
    .re_i    (w_emit),
    .raddr_i (r_cnt[CNT_W-1:1]),
    .rdata_o (w_rd_data)
  );

  // Coordinates and valid travel alongside the registered buffer read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_vld_pipe <= '0;
      r_s1       <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_emit};
      if (w_emit) begin
        r_s1.col <= COORD_W'(r_cnt);
        r_s1.row <= {r_row_q[COORD_W-2:0], (r_state == EMIT_ODD)};
      end
    end
  end

`ifdef UPSAMPLER_0_ZERO_STUFF_EN
  localparam logic [FP_WIDTH_REG-1:0] FP_ZERO = FP_WIDTH_REG'(fp_zero(EXP_WIDTH, FRAC_WIDTH));
  assign w_out_data = (r_s1.col[0] | r_s1.row[0]) ? FP_ZERO : w_rd_data;
`else
  assign w_out_data = w_rd_data;
`endif

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_data_o <= '0;
      r_col_o  <= '0;
      r_row_o  <= '0;
    end else if (r_vld_pipe[1]) begin
      r_data_o <= w_out_data;
      r_col_o  <= r_s1.col;
      r_row_o  <= r_s1.row;
    end
  end

  assign ready_o = r_ready;
  assign valid_o = r_vld_pipe[STAGES];
  assign data_o  = r_data_o;
  assign col_o   = r_col_o;
  assign row_o   = r_row_o;

endmodule

// File: tb/tb_upsampler_0_fp16.sv
// Self-checking bench for upsampler_0_fp16 (IN_WIDTH=4), scoreboard based.
module tb_upsampler_0_fp16;

  localparam int IW = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [15:0] data_i = '0, col_i = '0, row_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o, valid_o;
  logic [15:0] data_o, col_o, row_o;

  typedef struct { logic [15:0] d; logic [15:0] c; logic [15:0] r; } exp_t;
  exp_t        sb[$];
  logic [15:0] mbuf [IW];
  int          checks = 0;
  int          errors = 0;

  upsampler_0_fp16 #(.EXP_WIDTH(5), .FRAC_WIDTH(10), .IN_WIDTH(IW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .col_i(col_i), .row_i(row_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o), .col_o(col_o),
    .row_o(row_o), .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard monitor: every valid output beat must match the queue head.
  always @(negedge clk_i) begin
    exp_t e;
    if (valid_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got d=%h c=%0d r=%0d, none expected", data_o, col_o, row_o);
      end else begin
        e = sb.pop_front();
        if (data_o !== e.d || col_o !== e.c || row_o !== e.r) begin
          errors++;
          $display("FAIL out_beat: got d=%h c=%0d r=%0d, want d=%h c=%0d r=%0d",
                   data_o, col_o, row_o, e.d, e.c, e.r);
        end
      end
    end
  end

  // Push the 2 x 2*IW expected beats for the buffered row.
  task automatic push_row(input logic [15:0] row);
    exp_t e;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2 * IW; c++) begin
`ifdef UPSAMPLER_0_ZERO_STUFF_EN
        e.d = ((c % 2) != 0 || r != 0) ? 16'h0000 : mbuf[c / 2];
`else
        e.d = mbuf[c / 2];
`endif
        e.c = 16'(c);
        e.r = 16'(32'(row) * 2 + r);
        sb.push_back(e);
      end
  endtask

  // Drive one row; returns how many cycles the first beat waited for ready.
  task automatic feed_row(input logic [IW-1:0][15:0] pix, input logic [15:0] row,
                          input bit gap, output int wait0);
    int n;
    wait0 = 0;
    for (int i = 0; i < IW; i++) begin
      @(negedge clk_i);
      valid_i = 1'b1; data_i = pix[i]; row_i = row; col_i = 16'(i);
      n = 0;
      while (!ready_o && n < 200) begin @(negedge clk_i); n++; end
      if (n >= 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: beat %0d not accepted, want accept within 200 cycles", i);
      end
      if (i == 0) wait0 = n;
      @(posedge clk_i);
      mbuf[i] = pix[i];
      if (i == IW - 1) push_row(row);
      #1;
      valid_i = 1'b0;
      if (gap && i != IW - 1) begin
        @(negedge clk_i); valid_i = 1'b0; data_i = 16'hFFFF;
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || valid_o) && n < 500) begin @(posedge clk_i); #1; n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding, want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ready_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    checks++; if (data_o !== 16'h0) begin errors++; $display("FAIL rst_data: got %h want 0", data_o); end
    checks++; if (col_o !== 16'h0) begin errors++; $display("FAIL rst_col: got %h want 0", col_o); end
    checks++; if (row_o !== 16'h0) begin errors++; $display("FAIL rst_row: got %h want 0", row_o); end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", ready_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b want 0", valid_o); end
  endtask

  task automatic test_basic();
    int w, lowcnt, n;
    feed_row({16'h4400, 16'h4200, 16'h4000, 16'h3C00}, 16'd5, 1'b0, w);
    lowcnt = 0; n = 0;
    do begin
      @(negedge clk_i); n++;
      if (n <= 2) begin
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL latency_early: n=%0d valid=%b want 0", n, valid_o); end
      end
      if (n == 3) begin
        checks++;
        if (valid_o !== 1'b1) begin errors++; $display("FAIL latency_first: valid=%b want 1", valid_o); end
      end
      if (!ready_o) lowcnt++;
    end while (!ready_o && n < 100);
    checks++;
    if (lowcnt != 4 * IW) begin errors++; $display("FAIL ready_low: got %0d cycles want %0d", lowcnt, 4 * IW); end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int w;
    feed_row({16'h4500, 16'h4600, 16'h4700, 16'h4800}, 16'd1, 1'b0, w);
    // Hold a new beat during the whole emit; it must not be consumed early.
    valid_i = 1'b1; data_i = 16'h5A5A; row_i = 16'd2; col_i = 16'd0;
    feed_row({16'h5D5D, 16'h5C5C, 16'h5B5B, 16'h5A5A}, 16'd2, 1'b0, w);
    checks++;
    if (w != 4 * IW) begin errors++; $display("FAIL bp_accept: waited %0d cycles want %0d", w, 4 * IW); end
    wait_drain();
  endtask

  task automatic test_gapped();
    int w;
    feed_row({16'h8000, 16'hFC00, 16'h0001, 16'h7C00}, 16'h8003, 1'b1, w);
    wait_drain();
  endtask

  task automatic test_reset_mid_emit();
    int w;
    feed_row({16'h1111, 16'h2222, 16'h3333, 16'h4444}, 16'd7, 1'b0, w);
    repeat (4) @(negedge clk_i);
    #2; rst_i = 1'b0; #1;
    sb.delete();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", valid_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", ready_o); end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL midrst_fill: ready=%b want 1", ready_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midrst_idle: valid=%b want 0", valid_o); end
    feed_row({16'hBC00, 16'hC000, 16'hC200, 16'hC400}, 16'd9, 1'b0, w);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_reset_mid_emit();
    repeat (3) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
